// File: rtl/tx_fct_credit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tx_fct_credit_ctrl
//  Purpose  : SpaceWire transmit-side flow-control-token (FCT) credit
//             controller. Queues FCT requests from the receive buffer,
//             hands them one at a time to the character encoder, and tracks
//             how much credit granted to the far end is still outstanding.
//             Flags N-Chars received without credit and requests refused
//             because the credit window is full.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   pclk_tx       in   transmit clock, rising edge
//   enable_tx     in   synchronous active-low reset
//   send_null_tx  in   clock enable; low freezes all state and outputs
//   send_fct_now  in   request level; each rising edge asks for one FCT
//   rx_char_rcvd  in   one-cycle pulse per N-Char received
//   fct_sent      in   one-cycle encoder acknowledge per FCT transmitted
//   fct_req       out  an FCT is available for transmission
//   fct_pending   out  queued FCTs not yet sent
//   credit_out    out  FCTs sent whose characters are not all received
//   credit_err    out  sticky: N-Char received with no credit
//   req_drop      out  sticky: request refused, window full
// ============================================================================
module tx_fct_credit_ctrl #(
   parameter int CNT_W         = 3,
   parameter int MAX_OUT       = 7,
   parameter int INIT_FCT      = 7,
   parameter int CHARS_PER_FCT = 8
) (
   input  logic             pclk_tx,
   input  logic             enable_tx,
   input  logic             send_null_tx,
   input  logic             send_fct_now,
   input  logic             rx_char_rcvd,
   input  logic             fct_sent,
   output logic             fct_req,
   output logic [CNT_W-1:0] fct_pending,
   output logic [CNT_W-1:0] credit_out,
   output logic             credit_err,
   output logic             req_drop
);

   localparam int CHAR_W = $clog2(CHARS_PER_FCT);

   typedef enum logic [0:0] {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                req_d;
   logic [CHAR_W-1:0]   char_cnt;

   logic [CNT_W-1:0]    pending_nxt;
   logic [CNT_W-1:0]    credit_nxt;
   logic [CHAR_W-1:0]   char_cnt_nxt;
   logic                fct_req_nxt;
   logic                credit_err_nxt;
   logic                req_drop_nxt;

   logic                run;
   logic                req_edge;
   logic [CNT_W:0]      win_sum;
   logic                accept;
   logic                refuse;
   logic                do_send;
   logic                consume;
   logic                wrap;
   logic                no_credit;

   // ------------------------------------------------------------------
   // Event decode. Window occupancy is summed one bit wider so that a
   // full window can never alias to a small value.
   // ------------------------------------------------------------------
   always_comb begin
      run       = (state == S_RUN);
      req_edge  = send_fct_now & ~req_d;
      win_sum   = {1'b0, fct_pending} + {1'b0, credit_out};
      accept    = run & req_edge & (win_sum <  (CNT_W+1)'(MAX_OUT));
      refuse    = run & req_edge & (win_sum >= (CNT_W+1)'(MAX_OUT));
      do_send   = run & fct_sent & (fct_pending != '0);
      consume   = run & rx_char_rcvd & (credit_out != '0);
      no_credit = run & rx_char_rcvd & (credit_out == '0);
      wrap      = consume & (char_cnt == CHAR_W'(CHARS_PER_FCT-1));
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      pending_nxt    = fct_pending;
      credit_nxt     = credit_out;
      char_cnt_nxt   = char_cnt;
      credit_err_nxt = credit_err | no_credit;
      req_drop_nxt   = req_drop | refuse;

      case (state)
         S_LOAD: begin
            pending_nxt = CNT_W'(INIT_FCT);
            state_nxt   = S_RUN;
         end
         S_RUN: begin
            // Accept and send in the same cycle cancel out.
            case ({accept, do_send})
               2'b10:   pending_nxt = fct_pending + CNT_W'(1);
               2'b01:   pending_nxt = fct_pending - CNT_W'(1);
               default: pending_nxt = fct_pending;
            endcase
            // Send and a wrapping consume in the same cycle cancel out.
            case ({do_send, wrap})
               2'b10:   credit_nxt = credit_out + CNT_W'(1);
               2'b01:   credit_nxt = credit_out - CNT_W'(1);
               default: credit_nxt = credit_out;
            endcase
            if (consume) begin
               char_cnt_nxt = wrap ? '0 : char_cnt + CHAR_W'(1);
            end
         end
         default: state_nxt = S_LOAD;
      endcase

      fct_req_nxt = (state_nxt == S_RUN) && (pending_nxt != '0);
   end

   // ------------------------------------------------------------------
   // Registers. req_d tracks the request level in every enabled cycle,
   // including S_LOAD, so a level held across reset release is not seen
   // as a fresh request.
   // ------------------------------------------------------------------
   always_ff @(posedge pclk_tx) begin
      if (!enable_tx) begin
         state       <= S_LOAD;
         req_d       <= 1'b0;
         char_cnt    <= '0;
         fct_pending <= '0;
         credit_out  <= '0;
         fct_req     <= 1'b0;
         credit_err  <= 1'b0;
         req_drop    <= 1'b0;
      end else if (send_null_tx) begin
         state       <= state_nxt;
         req_d       <= send_fct_now;
         char_cnt    <= char_cnt_nxt;
         fct_pending <= pending_nxt;
         credit_out  <= credit_nxt;
         fct_req     <= fct_req_nxt;
         credit_err  <= credit_err_nxt;
         req_drop    <= req_drop_nxt;
      end
   end

endmodule
`default_nettype wire

// File: doc/tx_fct_credit_ctrl.md
# tx_fct_credit_ctrl

Parametrised flow-control-token (FCT) credit controller for the SpaceWire transmit side. It queues FCT requests raised by the receive buffer and hands them one at a time to the character encoder. It also tracks how much credit has been granted to the far end and is still outstanding, using the received N-Char stream. The block detects credit errors and requests that arrive while the credit window is full.

## Interface
- CNT_W, 3: width of `fct_pending` and `credit_out`; must satisfy 2^CNT_W > MAX_OUT
- MAX_OUT, 7: maximum FCTs queued plus outstanding (ECSS window = 7 × 8 = 56 chars)
- INIT_FCT, 7: FCTs queued automatically after reset; must be ≤ MAX_OUT
- CHARS_PER_FCT, 8: N-Chars covered by one FCT; power of two, ≥ 2
- pclk_tx  in  1  transmit clock; all logic on its rising edge
- enable_tx  in  1  synchronous, active-low reset
- send_null_tx  in  1  clock enable; when low, all state and outputs hold and all inputs are ignored
- send_fct_now  in  1  level from the receive buffer; each rising edge requests one FCT
- rx_char_rcvd  in  1  one-cycle pulse per N-Char received from the link
- fct_sent  in  1  one-cycle encoder acknowledge per FCT transmitted
- fct_req  out  1  FCT available for transmission
- fct_pending  out  CNT_W  queued FCTs not yet sent
- credit_out  out  CNT_W  FCTs sent whose characters are not fully received
- credit_err  out  1  sticky; an N-Char was received with no credit
- req_drop  out  1  sticky; a request was refused because the window was full

## Operation
- The FSM has two states, S_LOAD and S_RUN. Reset enters S_LOAD.
- In S_LOAD, the first enabled cycle loads `fct_pending` with INIT_FCT and moves to S_RUN. A request edge in that cycle is ignored.
- S_RUN is left only by reset.
- Edge detect:
  - `req_d` is a registered copy of `send_fct_now`, updated only in enabled cycles.
  - A request is `send_fct_now & ~req_d`.
  - `req_d` resets to 0.
- Request acceptance (S_RUN):
  - A request is accepted when `fct_pending + credit_out < MAX_OUT`. Evaluate the sum at CNT_W+1 bits using pre-update values.
  - If accepted, `fct_pending` increments.
  - If refused, `req_drop` is set and the counters are unchanged.
- Send:
  - `fct_sent` with `fct_pending > 0` decrements `fct_pending` and increments `credit_out`.
  - `fct_sent` with `fct_pending == 0` is ignored.
- Consume: `char_cnt` is internal, log2(CHARS_PER_FCT) bits wide, and resets to 0.
  - `rx_char_rcvd` with `credit_out > 0` increments `char_cnt`.
  - When `char_cnt == CHARS_PER_FCT-1`, the increment instead wraps `char_cnt` to 0 and decrements `credit_out`.
  - `rx_char_rcvd` with `credit_out == 0` sets `credit_err`; `char_cnt` and `credit_out` are unchanged.
- Simultaneous events: each counter's increment and decrement combine.
  - Accept + send: `fct_pending` is unchanged.
  - Send + wrapping consume: `credit_out` is unchanged.
- `fct_req` = (state == S_RUN) && (`fct_pending` != 0).
- Counters never wrap; the acceptance rule and guards keep both in 0..MAX_OUT.
- Sticky flags clear only on reset.

## Timing
- Reset values: `fct_req`=0, `fct_pending`=0, `credit_out`=0, `credit_err`=0, `req_drop`=0, state=S_LOAD.
- All outputs are registered.
- An input sampled in an enabled cycle affects outputs after that same edge (latency 1).
- First enabled cycle after reset release: `fct_pending`=INIT_FCT and `fct_req`=1 after that edge.
- Encoder handshake:
  - The encoder starts an FCT only while `fct_req`=1.
  - It pulses `fct_sent` once, at the end of that FCT.
  - `fct_req` may stay high across back-to-back FCTs.
- Reset mid-operation: all counters, `req_d`, flags and state return to reset values on the next edge with `enable_tx`=0, regardless of `send_null_tx`.
- A `send_fct_now` high level held across reset release is not a request, because `req_d` is loaded during S_LOAD.

## Test plan
- Init: reset 2 cycles, then `enable_tx`=1 with `send_null_tx`=1 -> after 1 edge, `fct_pending`=7, `fct_req`=1, `credit_out`=0.
- Drain and full window: 7 `fct_sent` pulses -> `fct_pending`=0, `credit_out`=7, `fct_req`=0. Then a `send_fct_now` rising edge -> `req_drop`=1, `fct_pending`=0.
- Consume and refill: from the full window, 8 `rx_char_rcvd` pulses -> `credit_out`=6. A rising edge -> `fct_pending`=1, `fct_req`=1.
- Credit error: consume all 56 characters -> `credit_out`=0. One more `rx_char_rcvd` -> `credit_err`=1 and the counters are unchanged.
- Simultaneous events: `fct_pending`=1, `credit_out`=3, `char_cnt`=7. Request edge + `fct_sent` + `rx_char_rcvd` in the same cycle -> `fct_pending`=1, `credit_out`=3, `char_cnt`=0.
- Gating and reset:
  - With `send_null_tx`=0, pulse `fct_sent`, `rx_char_rcvd` and a request edge -> no change.
  - Assert `enable_tx`=0 mid-drain -> all outputs 0 and state S_LOAD after 1 edge.
